// File: rtl/ext_pipe_if.sv
// Handshake bundle for ext_pipe: input beat side plus output FIFO head side.
// The master drives beats and out_ready; the slave (ext_pipe) returns results.
interface ext_pipe_if #(
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
);
    localparam int OFF_W = $clog2(OUT_W / 8);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [OUT_W-1:0] in_data;
    logic [OFF_W-1:0] in_off;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_exc;
    logic [TAG_W-1:0] out_tag;
    logic [LVL_W-1:0] level;

    modport master (
        output in_valid, in_op, in_data, in_off, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_exc, out_tag, level
    );

    modport slave (
        input  in_valid, in_op, in_data, in_off, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_exc, out_tag, level
    );
endinterface

// File: rtl/ext_pipe.sv
// Operand extender (immediate and load-lane modes) feeding a circular output FIFO.
// Macro EXT_PIPE_ALIGN_CHK_EN enables the per-entry halfword misalignment flag.
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic         clk,
    input  logic         reset,
    ext_pipe_if.slave    bus
);
    localparam int OFF_W = $clog2(OUT_W / 8);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB    = OUT_W / 8;
    localparam int NH    = OUT_W / 16;

    localparam logic [2:0] OP_ZERO = 3'd0;
    localparam logic [2:0] OP_SIGN = 3'd1;
    localparam logic [2:0] OP_LUI  = 3'd2;
    localparam logic [2:0] OP_BZ   = 3'd3;
    localparam logic [2:0] OP_BS   = 3'd4;
    localparam logic [2:0] OP_HZ   = 3'd5;
    localparam logic [2:0] OP_HS   = 3'd6;

    logic [7:0]        w_byte [NB];
    logic [15:0]       w_half [NH];
    logic [7:0]        w_sel_byte;
    logic [15:0]       w_sel_half;
    logic [IN_W-1:0]   w_imm;
    logic [OUT_W-1:0]  w_result;
    logic              w_in_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_nonempty;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_count;
    logic [OUT_W-1:0]  r_mem_data [DEPTH];
    logic [TAG_W-1:0]  r_mem_tag  [DEPTH];

    // Little-endian lane views of the operand.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            assign w_byte[gi] = bus.in_data[gi*8 +: 8];
        end
        for (genvar gi = 0; gi < NH; gi++) begin : g_half
            assign w_half[gi] = bus.in_data[gi*16 +: 16];
        end
    endgenerate

    // Halfword select drops in_off[0]; a misaligned beat still yields the aligned lane.
    assign w_sel_byte = w_byte[bus.in_off];
    assign w_sel_half = w_half[bus.in_off[OFF_W-1:1]];
    assign w_imm      = bus.in_data[IN_W-1:0];

    always_comb begin
        w_result = bus.in_data;
        case (bus.in_op)
            OP_ZERO: w_result = {{(OUT_W-IN_W){1'b0}}, w_imm};
            OP_SIGN: w_result = {{(OUT_W-IN_W){w_imm[IN_W-1]}}, w_imm};
            OP_LUI:  w_result = {w_imm, {(OUT_W-IN_W){1'b0}}};
            OP_BZ:   w_result = {{(OUT_W-8){1'b0}}, w_sel_byte};
            OP_BS:   w_result = {{(OUT_W-8){w_sel_byte[7]}}, w_sel_byte};
            OP_HZ:   w_result = {{(OUT_W-16){1'b0}}, w_sel_half};
            OP_HS:   w_result = {{(OUT_W-16){w_sel_half[15]}}, w_sel_half};
            default: w_result = bus.in_data;
        endcase
    end

    // A full FIFO can still take a beat when the head leaves in the same cycle.
    assign w_nonempty = (r_count != '0);
    assign w_in_ready = (r_count < LVL_W'(DEPTH)) || bus.out_ready;
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = w_nonempty && bus.out_ready;

    function automatic logic [PTR_W-1:0] f_ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_ptr_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy gates every read, and the head is read
    // asynchronously so a result is visible the cycle after it is accepted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_result;
            r_mem_tag[r_wr_ptr]  <= bus.in_tag;
        end
    end

`ifdef EXT_PIPE_ALIGN_CHK_EN
    logic w_exc;
    logic r_mem_exc [DEPTH];

    assign w_exc = ((bus.in_op == OP_HZ) || (bus.in_op == OP_HS)) && bus.in_off[0];

    always_ff @(posedge clk) begin
        if (w_push) r_mem_exc[r_wr_ptr] <= w_exc;
    end

    assign bus.out_exc = w_nonempty ? r_mem_exc[r_rd_ptr] : 1'b0;
`else
    assign bus.out_exc = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_nonempty;
    assign bus.out_data  = w_nonempty ? r_mem_data[r_rd_ptr] : '0;
    assign bus.out_tag   = w_nonempty ? r_mem_tag[r_rd_ptr]  : '0;
    assign bus.level     = r_count;
endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: drivers queue expected entries on acceptance,
// a monitor pops and compares on every output handshake.
module tb_ext_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ext_pipe_if #(.OUT_W(32), .DEPTH(2), .TAG_W(5)) bus ();

    ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2), .TAG_W(5)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

`ifdef EXT_PIPE_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int cyc      = 0;
    logic [37:0] sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: samples mid low phase, when every driven input is stable.
    initial begin : monitor
        logic [37:0] e;
        logic [37:0] a;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                a = {bus.out_data, bus.out_exc, bus.out_tag};
                checks++;
                pops++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out: got data=0x%08h exc=%0b tag=0x%02h expected no output",
                             a[37:6], a[5], a[4:0]);
                end else begin
                    e = sb.pop_front();
                    if (a !== e) begin
                        failures++;
                        $display("FAIL out_entry: got data=0x%08h exc=%0b tag=0x%02h expected data=0x%08h exc=%0b tag=0x%02h",
                                 a[37:6], a[5], a[4:0], e[37:6], e[5], e[4:0]);
                    end else begin
                        $display("out tag=0x%02h data=0x%08h exc=%0b ok", a[4:0], a[37:6], a[5]);
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [1:0] off,
                        input logic [4:0] tag, input logic [31:0] ed, input logic ee);
        int  n    = 0;
        bit  done = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_off   = off;
        bus.in_tag   = tag;
        while (!done) begin
            #1;
            done = bus.in_ready;
            @(posedge clk);
            if (done) begin
                sb.push_back({ed, ee & ALIGN, tag});
            end else begin
                n++;
                if (n > 50) begin
                    checks++;
                    failures++;
                    $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected 1 (tag 0x%02h)", tag);
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic lat_chk(input string name, input logic [31:0] ed, input logic ee, input logic [4:0] tag);
        idle();
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_data"}, bus.out_data, ed);
        chk({name, "_exc"}, 32'(bus.out_exc), 32'(ee & ALIGN));
        chk({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (bus.level != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(bus.level), 32'd0);
    endtask

    initial begin : stim
        int p0;
        int c0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_data   = '0;
        bus.in_off    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_data", bus.out_data, 32'd0);
        #10;
        rst_n = 1'b1;

        // Immediate modes, each checked the cycle after acceptance.
        send(3'd0, 32'h0000_8001, 2'd0, 5'd1, 32'h0000_8001, 1'b0);
        lat_chk("zero", 32'h0000_8001, 1'b0, 5'd1);
        send(3'd1, 32'h0000_8001, 2'd0, 5'd2, 32'hFFFF_8001, 1'b0);
        lat_chk("sign", 32'hFFFF_8001, 1'b0, 5'd2);
        send(3'd2, 32'h0000_8001, 2'd0, 5'd3, 32'h8001_0000, 1'b0);
        lat_chk("lui", 32'h8001_0000, 1'b0, 5'd3);
        send(3'd7, 32'h1234_5678, 2'd3, 5'd4, 32'h1234_5678, 1'b0);
        lat_chk("pass", 32'h1234_5678, 1'b0, 5'd4);

        // Lane modes, back to back.
        send(3'd4, 32'h80FF_7F01, 2'd2, 5'd5,  32'hFFFF_FFFF, 1'b0);
        send(3'd3, 32'h80FF_7F01, 2'd3, 5'd6,  32'h0000_0080, 1'b0);
        send(3'd6, 32'h80FF_7F01, 2'd2, 5'd7,  32'hFFFF_80FF, 1'b0);
        send(3'd5, 32'h80FF_7F01, 2'd0, 5'd8,  32'h0000_7F01, 1'b0);
        send(3'd4, 32'h80FF_7F01, 2'd1, 5'd9,  32'h0000_007F, 1'b0);
        send(3'd5, 32'h80FF_7F01, 2'd3, 5'd10, 32'h0000_80FF, 1'b1);
        idle();

        // Misaligned signed halfword.
        send(3'd6, 32'h80FF_7F01, 2'd1, 5'h1A, 32'h0000_7F01, 1'b1);
        lat_chk("misalign", 32'h0000_7F01, 1'b1, 5'h1A);
        wait_empty("lanes_drained");

        // Back-pressure with a two-entry FIFO.
        bus.out_ready = 1'b0;
        send(3'd7, 32'hA000_0001, 2'd0, 5'd11, 32'hA000_0001, 1'b0);
        idle();
        chk("bp_level1", 32'(bus.level), 32'd1);
        send(3'd7, 32'hA000_0002, 2'd0, 5'd12, 32'hA000_0002, 1'b0);
        idle();
        chk("bp_level2", 32'(bus.level), 32'd2);
        fork
            send(3'd7, 32'hA000_0003, 2'd0, 5'd13, 32'hA000_0003, 1'b0);
            begin
                @(negedge clk);
                #1;
                chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
                @(negedge clk);
                bus.out_ready = 1'b1;
                #1;
                chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
            end
        join
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("bp_level_same_cycle", 32'(bus.level), 32'd2);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        wait_empty("bp_drained");

        // Streaming: one beat per cycle, pointers wrap repeatedly.
        p0 = pops;
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            send(3'd0, 32'hFFFF_0000 | 32'(i * 3), 2'd0, 5'(i), 32'(i * 3), 1'b0);
        end
        chk("stream_cycles", 32'(cyc - c0), 32'd16);
        idle();
        wait_empty("stream_drained");
        chk("stream_pops", 32'(pops - p0), 32'd16);

        // Asynchronous reset with two entries queued.
        bus.out_ready = 1'b0;
        send(3'd7, 32'hAAAA_5555, 2'd0, 5'd20, 32'hAAAA_5555, 1'b0);
        send(3'd7, 32'h5555_AAAA, 2'd0, 5'd21, 32'h5555_AAAA, 1'b0);
        idle();
        chk("pre_rst_level", 32'(bus.level), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_level", 32'(bus.level), 32'd0);
        chk("mid_rst_out_data", bus.out_data, 32'd0);
        chk("mid_rst_out_tag", 32'(bus.out_tag), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        p0 = pops;
        send(3'd1, 32'h0000_7FFF, 2'd0, 5'd22, 32'h0000_7FFF, 1'b0);
        idle();
        wait_empty("post_rst_drained");
        repeat (3) @(negedge clk);
        chk("post_rst_pops", 32'(pops - p0), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, pipelined operand extender with a valid/ready handshake and an output FIFO of configurable depth. It covers immediate extension (zero/sign/upper) and load-data extension (byte/halfword lane select, zero or sign), so one block serves both the decode-stage immediate path and the memory-stage load path. Results carry a sideband tag and an alignment-exception flag, and they leave through the FIFO so a downstream stall does not drop data.

## Interface
Parameters:
- `IN_W`, 16, immediate width; must be less than `OUT_W`.
- `OUT_W`, 32, result and data width; multiple of 16, at least 32.
- `DEPTH`, 2, output FIFO entries; at least 1.
- `TAG_W`, 5, sideband tag width, passed through unchanged.

Derived: `OFF_W = $clog2(OUT_W/8)`, `LVL_W = $clog2(DEPTH+1)`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `in_op`  in  3  extension mode, see Operation.
- `in_data`  in  `OUT_W`  operand; immediate modes use `[IN_W-1:0]`.
- `in_off`  in  `OFF_W`  byte offset for lane modes.
- `in_tag`  in  `TAG_W`  sideband tag.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer takes the head entry.
- `out_data`  out  `OUT_W`  extended result.
- `out_exc`  out  1  misaligned-access flag.
- `out_tag`  out  `TAG_W`  tag of the head entry.
- `level`  out  `LVL_W`  FIFO occupancy.

## Operation
Modes. `d = in_data`. "Lane" means the byte or halfword of `d` selected by `in_off`.
- 0 ZERO: `{0, d[IN_W-1:0]}`.
- 1 SIGN: `d[IN_W-1:0]` sign-extended to `OUT_W`.
- 2 LUI: `{d[IN_W-1:0], (OUT_W-IN_W) zeros}`.
- 3 BZ: byte lane `in_off`, zero-extended.
- 4 BS: byte lane `in_off`, sign-extended.
- 5 HZ: halfword lane `in_off[OFF_W-1:1]`, zero-extended.
- 6 HS: halfword lane `in_off[OFF_W-1:1]`, sign-extended.
- 7 PASS: `d` unchanged.

Lane numbering is little-endian: lane 0 is bits `[7:0]`.

Exception:
- `exc` is 1 for modes 5 and 6 when `in_off[0] = 1`; otherwise 0.
- The result for a misaligned beat is still computed with `in_off[0]` ignored.

FIFO:
- Circular buffer with write pointer, read pointer and count. Pointers wrap from `DEPTH-1` to 0.
- Push condition: `in_valid && in_ready`. The pushed entry is `{result, exc, in_tag}`.
- Pop condition: `out_valid && out_ready`.
- `in_ready = (count < DEPTH) || out_ready`. When full, a simultaneous pop frees the slot for the push in the same cycle.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pop when empty and push when `in_ready = 0` are impossible by construction. Input signals are ignored whenever `in_valid = 0`.
- `out_valid = (count != 0)`. `level = count`.
- `out_data`, `out_exc` and `out_tag` show the head entry when non-empty and are forced to 0 when empty.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on the outputs after edge N, with `out_valid = 1` in cycle N+1.
- Throughput is 1 beat per cycle while `out_ready = 1`, at any `DEPTH`.
- `in_ready` is combinational from count and `out_ready`; there is no combinational path from `in_*` to `out_*`.
- Reset (`reset = 0`, asynchronous) clears count and both pointers immediately.
- Output values while reset is asserted:
  - `out_valid = 0`.
  - `out_data = 0`, `out_exc = 0`, `out_tag = 0`.
  - `level = 0`.
  - `in_ready = 1`, but no push occurs while reset is asserted.
- Reset mid-stream discards all queued entries. The first beat after release is accepted on the first rising edge with `reset = 1`.
- Reset release is synchronised externally; the block does not add a release stage.

## Configuration
- Macro `EXT_PIPE_ALIGN_CHK_EN`.
- Defined: the misalignment check is active and `exc` is stored per entry as described in Operation.
- Undefined: `out_exc` is tied to 0 and no `exc` bit is stored. Results for modes 5 and 6 are unchanged, still ignoring `in_off[0]`.

## Test plan
- Immediate modes, `IN_W = 16`, `OUT_W = 32`, `d = 0x0000_8001`:
  - ZERO -> `0x0000_8001`.
  - SIGN -> `0xFFFF_8001`.
  - LUI -> `0x8001_0000`.
  - Each result appears one cycle after acceptance.
- Lane modes with `d = 0x80FF_7F01`:
  - BS, off=2 -> `0xFFFF_FFFF`.
  - BZ, off=3 -> `0x0000_0080`.
  - HS, off=2 -> `0xFFFF_80FF`.
  - HZ, off=0 -> `0x0000_7F01`.
  - `exc = 0` for all four.
- Misaligned beat: HS with off=1 and tag 0x1A -> `out_exc = 1`, `out_tag = 0x1A`, `out_data = 0x0000_7F01`. Rebuilt with the macro undefined -> `out_exc = 0` and the same data.
- Back-pressure, `DEPTH = 2`:
  - Hold `out_ready = 0` and push 3 beats -> `level` goes 1, 2; `in_ready = 0` on the third beat.
  - Assert `out_ready` -> the third beat is accepted in that same cycle and `level` stays 2.
  - Drain -> outputs come out in order and `level` reaches 0.
- Streaming: 16 back-to-back beats with `out_ready = 1` and tags 0..15 -> 16 consecutive `out_valid` cycles, tags in order, pointers wrapping cleanly.
- Reset mid-stream: with 2 entries queued, pulse `reset` low for half a cycle -> `out_valid`, `level`, `out_data` and `out_tag` go to 0 immediately; the next beat's result is the only output afterwards.
